ir_fetch_unit: RTL and testbench



---
 rtl/mcpu_pkg.sv | 32 +++
 rtl/ir_field_split.sv | 26 ++
 rtl/ir_fetch_unit.sv | 124 ++++++++++++
 tb/tb_ir_fetch_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_pkg.sv
// Shared definitions for the multi-cycle MIPS fetch stage: fetch FSM state
// constants, instruction field bit positions and the reset instruction.
package mcpu_pkg;

   // Fetch FSM state; constants kept as plain localparams for legacy tools
   typedef logic [1:0] fetch_state_t;
   localparam fetch_state_t IDLE = 2'd0;
   localparam fetch_state_t WAIT = 2'd1;
   localparam fetch_state_t DONE = 2'd2;

   // Instruction field bit positions (MIPS R/I/J formats)
   localparam int OP_HI    = 31;
   localparam int OP_LO    = 26;
   localparam int RS_HI    = 25;
   localparam int RS_LO    = 21;
   localparam int RT_HI    = 20;
   localparam int RT_LO    = 16;
   localparam int RD_HI    = 15;
   localparam int RD_LO    = 11;
   localparam int SHAMT_HI = 10;
   localparam int SHAMT_LO = 6;
   localparam int FUNCT_HI = 5;
   localparam int FUNCT_LO = 0;
   localparam int IMM_HI   = 15;
   localparam int IMM_LO   = 0;
   localparam int JADDR_HI = 25;
   localparam int JADDR_LO = 0;

   // sll $0,$0,0 -- the canonical MIPS nop
   localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/ir_field_split.sv
// Purely combinational decode of the instruction register into its fields.
// This is the single place where field slicing is defined.
module ir_field_split
   import mcpu_pkg::*;
(
   input  logic [31:0] ir,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic [15:0] imm16,
   output logic [25:0] jaddr
);

   assign opcode = ir[OP_HI:OP_LO];
   assign rs     = ir[RS_HI:RS_LO];
   assign rt     = ir[RT_HI:RT_LO];
   assign rd     = ir[RD_HI:RD_LO];
   assign shamt  = ir[SHAMT_HI:SHAMT_LO];
   assign funct  = ir[FUNCT_HI:FUNCT_LO];
   assign imm16  = ir[IMM_HI:IMM_LO];
   assign jaddr  = ir[JADDR_HI:JADDR_LO];

endmodule

// File: rtl/ir_fetch_unit.sv
// Instruction fetch / IR stage of the multi-cycle MIPS CPU. Reads one word
// from instruction memory using a ready handshake, latches it into IR and
// provides PC+4 plus the decoded instruction fields. Only DATA_W=32 is
// meaningful since the field layout is fixed by the MIPS ISA.
module ir_fetch_unit
   import mcpu_pkg::*;
#(
   parameter int                 DATA_W   = 32,
   parameter logic [DATA_W-1:0]  RESET_IR = NOP
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_req,
   input  logic              flush,
   input  logic [DATA_W-1:0] pc_in,
   output logic              mem_rd,
   output logic [DATA_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              fetch_done,
   output logic              addr_err,
   output logic [DATA_W-1:0] ir,
   output logic [DATA_W-1:0] pc_plus4,
   output logic [5:0]        opcode,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        rd,
   output logic [4:0]        shamt,
   output logic [5:0]        funct,
   output logic [15:0]       imm16,
   output logic [25:0]       jaddr
);

   fetch_state_t      state;
   logic [DATA_W-1:0] pc_lat;
   logic              start;
   logic              capture;

   // A new fetch starts only from IDLE with an aligned address; flush vetoes it.
   // Flush also beats a same-edge mem_ready so late data is dropped.
   assign start   = (state == IDLE) && fetch_req && !flush && (pc_in[1:0] == 2'b00);
   assign capture = (state == WAIT) && mem_ready && !flush;

   // The memory address is simply the latched PC, which stays put for the whole WAIT.
   assign mem_addr = pc_lat;

   // Fetch FSM and its registered control outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         mem_rd     <= 1'b0;
         busy       <= 1'b0;
         fetch_done <= 1'b0;
         addr_err   <= 1'b0;
      end else begin
         fetch_done <= 1'b0;
         addr_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= WAIT;
                  mem_rd <= 1'b1;
                  busy   <= 1'b1;
               end else if (fetch_req && !flush) begin
                  addr_err <= 1'b1;
               end
            end
            WAIT: begin
               if (flush) begin
                  state  <= IDLE;
                  mem_rd <= 1'b0;
                  busy   <= 1'b0;
               end else if (mem_ready) begin
                  state      <= DONE;
                  mem_rd     <= 1'b0;
                  fetch_done <= 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy   <= 1'b0;
               mem_rd <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy   <= 1'b0;
               mem_rd <= 1'b0;
            end
         endcase
      end
   end

   // Address latch, instruction register and PC+4 (wraps naturally mod 2^32)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_lat   <= '0;
         ir       <= RESET_IR;
         pc_plus4 <= '0;
      end else begin
         if (start) begin
            pc_lat <= pc_in;
         end
         if (capture) begin
            ir       <= mem_rdata;
            pc_plus4 <= pc_lat + DATA_W'(4);
         end
      end
   end

   ir_field_split u_split (
      .ir     (ir[31:0]),
      .opcode (opcode),
      .rs     (rs),
      .rt     (rt),
      .rd     (rd),
      .shamt  (shamt),
      .funct  (funct),
      .imm16  (imm16),
      .jaddr  (jaddr)
   );

endmodule

// File: tb/tb_ir_fetch_unit.sv
// Bench for ir_fetch_unit: a table of directed fetch transactions with fixed
// expected results, hand-written reset/flush sequences, then randomized
// transactions checked against a transaction-level reference model.
module tb_ir_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        fetch_req;
   logic        flush;
   logic [31:0] pc_in;
   logic        mem_rd;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        busy;
   logic        fetch_done;
   logic        addr_err;
   logic [31:0] ir;
   logic [31:0] pc_plus4;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [15:0] imm16;
   logic [25:0] jaddr;

   int total = 0;
   int bad   = 0;

   // reference model state: what IR and PC+4 must hold between fetches
   logic [31:0] exp_ir;
   logic [31:0] exp_pc4;

   ir_fetch_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fetch_req  (fetch_req),
      .flush      (flush),
      .pc_in      (pc_in),
      .mem_rd     (mem_rd),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .busy       (busy),
      .fetch_done (fetch_done),
      .addr_err   (addr_err),
      .ir         (ir),
      .pc_plus4   (pc_plus4),
      .opcode     (opcode),
      .rs         (rs),
      .rt         (rt),
      .rd         (rd),
      .shamt      (shamt),
      .funct      (funct),
      .imm16      (imm16),
      .jaddr      (jaddr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Every field is the instruction word shifted and masked per the MIPS format.
   task automatic chk_state(input string tag);
      chk({tag, ".ir"},     ir,       exp_ir);
      chk({tag, ".pc4"},    pc_plus4, exp_pc4);
      chk({tag, ".opcode"}, 32'(opcode), (exp_ir >> 26) & 32'h3F);
      chk({tag, ".rs"},     32'(rs),     (exp_ir >> 21) & 32'h1F);
      chk({tag, ".rt"},     32'(rt),     (exp_ir >> 16) & 32'h1F);
      chk({tag, ".rd"},     32'(rd),     (exp_ir >> 11) & 32'h1F);
      chk({tag, ".shamt"},  32'(shamt),  (exp_ir >> 6)  & 32'h1F);
      chk({tag, ".funct"},  32'(funct),  exp_ir & 32'h3F);
      chk({tag, ".imm16"},  32'(imm16),  exp_ir & 32'hFFFF);
      chk({tag, ".jaddr"},  32'(jaddr),  exp_ir & 32'h03FF_FFFF);
   endtask

   // One fetch transaction: request at addr, memory answers after 'waits'
   // stall cycles with 'data'; 'fl' raises flush together with mem_ready.
   // Stray fetch_req pulses are thrown in during WAIT and DONE.
   task automatic run_fetch(input logic [31:0] addr, input int waits,
                            input logic [31:0] data, input bit fl, input string tag);
      @(negedge clk);
      fetch_req = 1'b1; pc_in = addr; flush = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      fetch_req = 1'b0;
      if (addr[1:0] != 2'b00) begin
         chk({tag, ".addr_err"}, 32'(addr_err), 32'd1);
         chk({tag, ".err_rd"},   32'(mem_rd),   32'd0);
         chk({tag, ".err_busy"}, 32'(busy),     32'd0);
         @(negedge clk);
         chk({tag, ".err_pulse"}, 32'(addr_err), 32'd0);
         chk({tag, ".err_rd2"},   32'(mem_rd),   32'd0);
         chk_state(tag);
         return;
      end
      for (int i = 0; i <= waits; i++) begin
         chk({tag, ".rd"},    32'(mem_rd),     32'd1);
         chk({tag, ".addr"},  mem_addr,        addr);
         chk({tag, ".busy"},  32'(busy),       32'd1);
         chk({tag, ".done0"}, 32'(fetch_done), 32'd0);
         mem_ready = (i == waits);
         mem_rdata = (i == waits) ? data : $urandom;
         flush     = fl && (i == waits);
         fetch_req = $urandom_range(0, 1);
         pc_in     = $urandom & 32'hFFFF_FFFC;
         @(negedge clk);
      end
      mem_ready = 1'b0; flush = 1'b0; mem_rdata = $urandom;
      if (fl) begin
         fetch_req = 1'b0;
         chk({tag, ".fl_done"}, 32'(fetch_done), 32'd0);
         chk({tag, ".fl_busy"}, 32'(busy),       32'd0);
         chk({tag, ".fl_rd"},   32'(mem_rd),     32'd0);
      end else begin
         exp_ir  = data;
         exp_pc4 = addr + 32'd4;
         chk({tag, ".done"},    32'(fetch_done), 32'd1);
         chk({tag, ".dn_busy"}, 32'(busy),       32'd1);
         chk({tag, ".dn_rd"},   32'(mem_rd),     32'd0);
         fetch_req = 1'b1;   // must be ignored in DONE
         pc_in     = 32'h0000_1000;
         @(negedge clk);
         fetch_req = 1'b0;
         chk({tag, ".done1"},   32'(fetch_done), 32'd0);
         chk({tag, ".idle"},    32'(busy),       32'd0);
         chk({tag, ".no_rd"},   32'(mem_rd),     32'd0);
      end
      chk_state(tag);
   endtask

   typedef struct {
      logic [31:0] addr;
      int          waits;
      logic [31:0] data;
      bit          fl;
      logic [31:0] e_ir;
      logic [31:0] e_pc4;
      logic [5:0]  e_op;
      logic [4:0]  e_rs;
      logic [4:0]  e_rt;
      logic [15:0] e_imm;
   } vec_t;

   vec_t vecs[6];

   initial begin
      rst_n = 1'b0; fetch_req = 1'b0; flush = 1'b0; pc_in = '0;
      mem_rdata = '0; mem_ready = 1'b0;
      exp_ir = 32'h0; exp_pc4 = 32'h0;

      vecs[0] = '{32'h0000_0040, 0, 32'h2008_FFFF, 1'b0, 32'h2008_FFFF, 32'h0000_0044, 6'h08, 5'd0, 5'd8,  16'hFFFF};
      vecs[1] = '{32'h0000_0100, 3, 32'h8C43_0010, 1'b0, 32'h8C43_0010, 32'h0000_0104, 6'h23, 5'd2, 5'd3,  16'h0010};
      vecs[2] = '{32'h0000_0200, 1, 32'hDEAD_BEEF, 1'b1, 32'h8C43_0010, 32'h0000_0104, 6'h23, 5'd2, 5'd3,  16'h0010};
      vecs[3] = '{32'h0000_0042, 0, 32'h1234_5678, 1'b0, 32'h8C43_0010, 32'h0000_0104, 6'h23, 5'd2, 5'd3,  16'h0010};
      vecs[4] = '{32'hFFFF_FFFC, 2, 32'h012A_4020, 1'b0, 32'h012A_4020, 32'h0000_0000, 6'h00, 5'd9, 5'd10, 16'h4020};
      vecs[5] = '{32'h0040_0000, 0, 32'h0810_0003, 1'b0, 32'h0810_0003, 32'h0040_0004, 6'h02, 5'd0, 5'd16, 16'h0003};

      // reset state
      repeat (2) @(negedge clk);
      chk("rst.ir",    ir,               32'h0);
      chk("rst.pc4",   pc_plus4,         32'h0);
      chk("rst.rd",    32'(mem_rd),      32'd0);
      chk("rst.addr",  mem_addr,         32'h0);
      chk("rst.busy",  32'(busy),        32'd0);
      chk("rst.done",  32'(fetch_done),  32'd0);
      chk("rst.err",   32'(addr_err),    32'd0);
      chk("rst.imm",   32'(imm16),       32'd0);
      rst_n = 1'b1;

      // directed table
      foreach (vecs[k]) begin
         run_fetch(vecs[k].addr, vecs[k].waits, vecs[k].data, vecs[k].fl, $sformatf("vec%0d", k));
         chk($sformatf("vec%0d.t_ir", k),  ir,              vecs[k].e_ir);
         chk($sformatf("vec%0d.t_pc4", k), pc_plus4,        vecs[k].e_pc4);
         chk($sformatf("vec%0d.t_op", k),  32'(opcode),     32'(vecs[k].e_op));
         chk($sformatf("vec%0d.t_rs", k),  32'(rs),         32'(vecs[k].e_rs));
         chk($sformatf("vec%0d.t_rt", k),  32'(rt),         32'(vecs[k].e_rt));
         chk($sformatf("vec%0d.t_imm", k), 32'(imm16),      32'(vecs[k].e_imm));
      end

      // flush in IDLE beats fetch_req, even for a misaligned address
      @(negedge clk);
      fetch_req = 1'b1; flush = 1'b1; pc_in = 32'h0000_0300;
      @(negedge clk);
      chk("idlefl.rd",   32'(mem_rd),   32'd0);
      chk("idlefl.busy", 32'(busy),     32'd0);
      pc_in = 32'h0000_0301;
      @(negedge clk);
      chk("idlefl.err",  32'(addr_err), 32'd0);
      fetch_req = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("idlefl.rd2",  32'(mem_rd),   32'd0);

      // asynchronous reset in the middle of WAIT
      fetch_req = 1'b1; pc_in = 32'h0000_0080;
      @(negedge clk);
      fetch_req = 1'b0;
      chk("mrst.pre_rd", 32'(mem_rd), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst.ir",   ir,           32'h0);
      chk("mrst.rd",   32'(mem_rd),  32'd0);
      chk("mrst.busy", 32'(busy),    32'd0);
      chk("mrst.imm",  32'(imm16),   32'd0);
      chk("mrst.pc4",  pc_plus4,     32'h0);
      exp_ir = 32'h0; exp_pc4 = 32'h0;
      @(negedge clk);
      rst_n = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mrst.no_done", 32'(fetch_done), 32'd0);
         chk("mrst.idle",    32'(busy),       32'd0);
      end
      mem_ready = 1'b0;
      chk_state("mrst");

      // randomized transactions against the reference model
      for (int n = 0; n < 40; n++) begin
         logic [31:0] a;
         a = $urandom;
         if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
         if (a[1:0] == 2'b00 && $urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC;
         run_fetch(a, $urandom_range(0, 4), $urandom, ($urandom_range(0, 4) == 0),
                   $sformatf("rnd%0d", n));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
